// File: rtl/user_pwm_capture_if.sv
// Avalon-MM slave bus bundle for user_pwm_capture.
interface user_pwm_capture_if;
  logic        avs_chipselect;
  logic [3:0]  avs_address;
  logic        avs_read;
  logic [31:0] avs_readdata;
  logic        avs_write;
  logic [31:0] avs_writedata;

  modport master (
    output avs_chipselect,
    output avs_address,
    output avs_read,
    output avs_write,
    output avs_writedata,
    input  avs_readdata
  );

  modport slave (
    input  avs_chipselect,
    input  avs_address,
    input  avs_read,
    input  avs_write,
    input  avs_writedata,
    output avs_readdata
  );
endinterface

// File: rtl/user_pwm_capture.sv
// Avalon-MM PWM capture: measures high time, period and sample count of coe_PWM_IN.
// Optional 3-sample glitch filter is enabled by defining PWM_CAP_GLITCH_FILTER_EN.
module user_pwm_capture #(
  parameter logic [31:0] TIMEOUT_RST = 32'd100000000
) (
  input  logic              csi_clk,
  input  logic              csi_reset_n,
  user_pwm_capture_if.slave avs,
  input  logic              coe_PWM_IN,
  output logic              ins_irq
);

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;

  localparam logic [AW-1:0] A_CTRL    = AW'(0);
  localparam logic [AW-1:0] A_STATUS  = AW'(1);
  localparam logic [AW-1:0] A_HIGH    = AW'(2);
  localparam logic [AW-1:0] A_PERIOD  = AW'(3);
  localparam logic [AW-1:0] A_TIMEOUT = AW'(4);
  localparam logic [AW-1:0] A_SAMPLES = AW'(5);
  localparam logic [DW-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic            lvl_q, lvl_d;
  logic [DW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   htmp_q, htmp_d;
  logic [DW-1:0]   high_q, high_d;
  logic [DW-1:0]   period_q, period_d;
  logic [DW-1:0]   timeout_q, timeout_d;
  logic [DW-1:0]   samples_q, samples_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [1:0]      ctrl_q, ctrl_d;
  logic            valid_q, valid_d;
  logic            ovr_q, ovr_d;
  logic            tmo_q, tmo_d;
  logic            irq_q, irq_d;

  logic            rise_c, fall_c;
  logic            wr_c, rd_c, tmo_hit_c;

`ifdef PWM_CAP_GLITCH_FILTER_EN
  logic            hist1_q, hist1_d;
  logic            hist2_q, hist2_d;
`endif

  // Synchronizer and (optional) agreement filter; lvl_d is the current filtered level.
  always_comb begin
    sync1_d = coe_PWM_IN;
    sync2_d = sync1_q;
`ifdef PWM_CAP_GLITCH_FILTER_EN
    hist1_d = sync2_q;
    hist2_d = hist1_q;
    if (sync2_q && hist1_q && hist2_q) begin
      lvl_d = 1'b1;
    end else if (!sync2_q && !hist1_q && !hist2_q) begin
      lvl_d = 1'b0;
    end else begin
      lvl_d = lvl_q;
    end
`else
    lvl_d = sync2_q;
`endif
  end

  assign rise_c    = lvl_d & ~lvl_q;
  assign fall_c    = ~lvl_d & lvl_q;
  assign wr_c      = avs.avs_chipselect & avs.avs_write;
  assign rd_c      = avs.avs_chipselect & avs.avs_read & ~wr_c;
  assign tmo_hit_c = (timeout_q != '0) && (cnt_q == timeout_q);

  always_comb begin
    state_d   = state_q;
    htmp_d    = htmp_q;
    high_d    = high_q;
    period_d  = period_q;
    samples_d = samples_q;
    timeout_d = timeout_q;
    ctrl_d    = ctrl_q;
    valid_d   = valid_q;
    ovr_d     = ovr_q;
    tmo_d     = tmo_q;
    rdata_d   = rdata_q;

    if (rise_c) begin
      cnt_d = DW'(1);
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + DW'(1);
    end

    // Register writes; status clears come first so a same-cycle set wins.
    if (wr_c) begin
      case (avs.avs_address)
        A_CTRL:    ctrl_d = avs.avs_writedata[1:0];
        A_STATUS: begin
          if (avs.avs_writedata[0]) valid_d = 1'b0;
          if (avs.avs_writedata[1]) ovr_d   = 1'b0;
          if (avs.avs_writedata[2]) tmo_d   = 1'b0;
        end
        A_TIMEOUT: timeout_d = avs.avs_writedata;
        default: ;
      endcase
    end

    if (!ctrl_q[0]) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rise_c) state_d = ST_HIGH;
        end
        ST_HIGH: begin
          if (tmo_hit_c) begin
            state_d = ST_IDLE;
            tmo_d   = 1'b1;
          end else if (fall_c) begin
            state_d = ST_LOW;
            htmp_d  = cnt_q;
          end
        end
        ST_LOW: begin
          if (tmo_hit_c) begin
            state_d = ST_IDLE;
            tmo_d   = 1'b1;
          end else if (rise_c) begin
            state_d   = ST_HIGH;
            high_d    = htmp_q;
            period_d  = cnt_q;
            samples_d = samples_q + DW'(1);
            valid_d   = 1'b1;
            if (valid_q) ovr_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (rd_c) begin
      case (avs.avs_address)
        A_CTRL:    rdata_d = DW'(ctrl_q);
        A_STATUS:  rdata_d = DW'({lvl_q, tmo_q, ovr_q, valid_q});
        A_HIGH:    rdata_d = high_q;
        A_PERIOD:  rdata_d = period_q;
        A_TIMEOUT: rdata_d = timeout_q;
        A_SAMPLES: rdata_d = samples_q;
        default:   rdata_d = '0;
      endcase
    end

    irq_d = ctrl_d[1] & (valid_d | tmo_d);
  end

  always_ff @(posedge csi_clk or negedge csi_reset_n) begin
    if (!csi_reset_n) begin
      state_q   <= ST_IDLE;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      lvl_q     <= 1'b0;
      cnt_q     <= '0;
      htmp_q    <= '0;
      high_q    <= '0;
      period_q  <= '0;
      timeout_q <= TIMEOUT_RST;
      samples_q <= '0;
      rdata_q   <= '0;
      ctrl_q    <= '0;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
      tmo_q     <= 1'b0;
      irq_q     <= 1'b0;
`ifdef PWM_CAP_GLITCH_FILTER_EN
      hist1_q   <= 1'b0;
      hist2_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      lvl_q     <= lvl_d;
      cnt_q     <= cnt_d;
      htmp_q    <= htmp_d;
      high_q    <= high_d;
      period_q  <= period_d;
      timeout_q <= timeout_d;
      samples_q <= samples_d;
      rdata_q   <= rdata_d;
      ctrl_q    <= ctrl_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
      tmo_q     <= tmo_d;
      irq_q     <= irq_d;
`ifdef PWM_CAP_GLITCH_FILTER_EN
      hist1_q   <= hist1_d;
      hist2_q   <= hist2_d;
`endif
    end
  end

  assign avs.avs_readdata = rdata_q;
  assign ins_irq          = irq_q;

endmodule

// File: tb/tb_user_pwm_capture.sv
// Directed + randomized bench for user_pwm_capture with a period-level reference model.
module tb_user_pwm_capture;

  logic clk;
  logic rst_n;
  logic pwm;
  logic irq;

  int n_assert = 0;
  int n_fail   = 0;

`ifdef PWM_CAP_GLITCH_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  localparam logic [3:0] A_CTRL = 4'd0, A_STATUS = 4'd1, A_HIGH = 4'd2,
                         A_PERIOD = 4'd3, A_TIMEOUT = 4'd4, A_SAMPLES = 4'd5;

  user_pwm_capture_if bus ();

  user_pwm_capture #(.TIMEOUT_RST(32'd100000000)) dut (
    .csi_clk     (clk),
    .csi_reset_n (rst_n),
    .avs         (bus.slave),
    .coe_PWM_IN  (pwm),
    .ins_irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic lv, input int n);
    pwm = lv;
    wait_cyc(n);
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    bus.avs_chipselect = 1'b1;
    bus.avs_write      = 1'b1;
    bus.avs_address    = a;
    bus.avs_writedata  = d;
    @(negedge clk);
    bus.avs_chipselect = 1'b0;
    bus.avs_write      = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    bus.avs_chipselect = 1'b1;
    bus.avs_read       = 1'b1;
    bus.avs_address    = a;
    @(negedge clk);
    bus.avs_chipselect = 1'b0;
    bus.avs_read       = 1'b0;
    d = bus.avs_readdata;
  endtask

  task automatic rd_chk(input logic [3:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] v;
    bus_read(a, v);
    check(tag, v, exp);
  endtask

  task automatic en_cycle();
    bus_write(A_CTRL, 32'd0);
    bus_write(A_CTRL, 32'd3);
    bus_write(A_STATUS, 32'h7);
  endtask

  // Reference state, advanced per driven period rather than per clock.
  logic [31:0] exp_samples, exp_high, exp_period;

  task automatic chk_reset_regs(input string pfx);
    rd_chk(A_CTRL,    32'd0,         {pfx, "_ctrl"});
    rd_chk(A_STATUS,  32'd0,         {pfx, "_status"});
    rd_chk(A_HIGH,    32'd0,         {pfx, "_high"});
    rd_chk(A_PERIOD,  32'd0,         {pfx, "_period"});
    rd_chk(A_TIMEOUT, 32'h05F5E100,  {pfx, "_timeout"});
    rd_chk(A_SAMPLES, 32'd0,         {pfx, "_samples"});
    rd_chk(4'd6,      32'd0,         {pfx, "_addr6"});
    rd_chk(4'd15,     32'd0,         {pfx, "_addr15"});
    check({pfx, "_irq"}, 32'(irq), 32'd0);
  endtask

  initial begin
    logic [31:0] v;
    int n, h, l, hl[$], ll[$];

    rst_n = 1'b0;
    pwm   = 1'b0;
    bus.avs_chipselect = 1'b0;
    bus.avs_read       = 1'b0;
    bus.avs_write      = 1'b0;
    bus.avs_address    = '0;
    bus.avs_writedata  = '0;
    wait_cyc(2);
    check("reset_readdata", bus.avs_readdata, 32'd0);
    rst_n = 1'b1;
    wait_cyc(2);

    chk_reset_regs("rst");

    // Read and write in the same cycle: write lands, readdata holds.
    bus_read(A_TIMEOUT, v);
    bus.avs_chipselect = 1'b1; bus.avs_read = 1'b1; bus.avs_write = 1'b1;
    bus.avs_address = A_CTRL; bus.avs_writedata = 32'd2;
    @(negedge clk);
    bus.avs_chipselect = 1'b0; bus.avs_read = 1'b0; bus.avs_write = 1'b0;
    check("rdwr_hold", bus.avs_readdata, 32'h05F5E100);
    rd_chk(A_CTRL, 32'd2, "rdwr_write");

    // Three 300/700 periods: two samples.
    bus_write(A_CTRL, 32'd3);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 300);
      drive(1'b0, 700);
    end
    exp_samples = 32'd2;
    rd_chk(A_HIGH,    32'd300,  "main_high");
    rd_chk(A_PERIOD,  32'd1000, "main_period");
    rd_chk(A_SAMPLES, 32'd2,    "main_samples");
    rd_chk(A_STATUS,  32'h3,    "main_status");
    check("main_irq", 32'(irq), 32'd1);

    bus_write(A_STATUS, 32'h3);
    check("clr_irq", 32'(irq), 32'd0);
    rd_chk(A_STATUS, 32'h0, "clr_status");
    bus_write(A_HIGH, 32'hDEADBEEF);
    rd_chk(A_HIGH, 32'd300, "ro_write_ignored");

    // Timeout: a single rise then held high.
    bus_write(A_TIMEOUT, 32'd500);
    en_cycle();
    drive(1'b1, 495);
    rd_chk(A_STATUS, 32'h8, "tmo_before");
    wait_cyc(16);
    rd_chk(A_STATUS, 32'hC, "tmo_after");
    check("tmo_irq", 32'(irq), 32'd1);
    rd_chk(A_SAMPLES, exp_samples, "tmo_samples");
    bus_write(A_STATUS, 32'h4);
    drive(1'b0, 100);
    drive(1'b1, 100);
    drive(1'b0, 100);
    drive(1'b1, 20);
    exp_samples++;
    rd_chk(A_SAMPLES, exp_samples, "post_tmo_samples");
    rd_chk(A_HIGH,    32'd100,     "post_tmo_high");
    rd_chk(A_PERIOD,  32'd200,     "post_tmo_period");
    bus_write(A_TIMEOUT, 32'd0);

    // Random bursts of periods from IDLE; last period closed by one extra rise.
    for (int b = 0; b < 4; b++) begin
      en_cycle();
      drive(1'b0, 10);
      n = $urandom_range(1, 5);
      hl.delete(); ll.delete();
      for (int i = 0; i < n; i++) begin
        hl.push_back($urandom_range(5, 60));
        ll.push_back($urandom_range(5, 60));
      end
      foreach (hl[i]) begin
        drive(1'b1, hl[i]);
        drive(1'b0, ll[i]);
      end
      drive(1'b1, 10);
      exp_samples = exp_samples + 32'(n);
      exp_high    = 32'(hl[n-1]);
      exp_period  = 32'(hl[n-1] + ll[n-1]);
      rd_chk(A_SAMPLES, exp_samples, "rnd_samples");
      rd_chk(A_HIGH,    exp_high,    "rnd_high");
      rd_chk(A_PERIOD,  exp_period,  "rnd_period");
      rd_chk(A_STATUS,  32'h9 | ((n > 1) ? 32'h2 : 32'h0), "rnd_status");
    end

    // 2-cycle low glitch inside a 300-cycle high phase.
    en_cycle();
    drive(1'b0, 10);
    drive(1'b1, 300);
    drive(1'b0, 700);
    drive(1'b1, 100);
    drive(1'b0, 2);
    pwm = 1'b1;
    wait_cyc(10);
    rd_chk(A_HIGH, FILT ? 32'd300 : 32'd100, "glitch_mid_high");
    wait_cyc(187);
    drive(1'b0, 700);
    drive(1'b1, 20);
    exp_samples = exp_samples + (FILT ? 32'd2 : 32'd3);
    rd_chk(A_SAMPLES, exp_samples, "glitch_samples");
    rd_chk(A_HIGH,   FILT ? 32'd300  : 32'd198, "glitch_high");
    rd_chk(A_PERIOD, FILT ? 32'd1000 : 32'd898, "glitch_period");

    // EN cleared mid-period: no sample.
    en_cycle();
    drive(1'b0, 10);
    drive(1'b1, 50);
    bus_write(A_CTRL, 32'd0);
    drive(1'b0, 50);
    drive(1'b1, 20);
    rd_chk(A_SAMPLES, exp_samples, "en_clr_samples");
    rd_chk(A_STATUS,  32'h8,       "en_clr_status");

    // Reset pulse mid-period.
    bus_write(A_CTRL, 32'd3);
    drive(1'b0, 20);
    drive(1'b1, 50);
    drive(1'b0, 30);
    rst_n = 1'b0;
    wait_cyc(2);
    check("rst_mid_irq", 32'(irq), 32'd0);
    check("rst_mid_readdata", bus.avs_readdata, 32'd0);
    rst_n = 1'b1;
    wait_cyc(10);
    chk_reset_regs("rst2");
    bus_write(A_CTRL, 32'd3);
    drive(1'b1, 40);
    drive(1'b0, 60);
    drive(1'b1, 10);
    rd_chk(A_SAMPLES, 32'd1,   "rst2_samples");
    rd_chk(A_HIGH,    32'd40,  "rst2_high");
    rd_chk(A_PERIOD,  32'd100, "rst2_period");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
